operand_fetch: RTL and testbench

- Upstream stage of the 16-bit ALU. Holds the 8x16 register file and fetches the two operands over a short multi-cycle sequence.
- Applies the shifter and the operand-select muxes, then presents Ain, Bin and ALUop to the ALU with a one-cycle valid strobe.
- Uses a single read port, so the two operands are read on consecutive cycles and captured into the A and B holding registers.

---
 rtl/operand_pkg.sv | 31 +++
 rtl/operand_fetch_regfile.sv | 40 ++++
 rtl/operand_fetch.sv | 145 ++++++++++++++
 tb/tb_operand_fetch.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_pkg.sv
// Shared encodings for the operand-fetch stage and the ALU it feeds.
package operand_pkg;

    localparam int W_DEF    = 16;
    localparam int NREG_DEF = 8;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD_A = 2'b01,
        RD_B = 2'b10,
        OUT  = 2'b11
    } state_e;

    // Shifter control applied to the B operand.
    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL  = 2'b01,
        SH_LSR  = 2'b10,
        SH_ASR  = 2'b11
    } shift_e;

    // ALU operation codes, shared with the ALU.
    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        AND = 2'b10,
        NOT = 2'b11
    } alu_op_e;

endpackage

// File: rtl/operand_fetch_regfile.sv
// NREG x W architectural register file: one write port, one combinational
// read port, cleared synchronously on reset.
module operand_fetch_regfile
    import operand_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int NREG = NREG_DEF,
    parameter int RW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          w_en,
    input  logic [RW-1:0] w_num,
    input  logic [W-1:0]  w_data,
    input  logic [RW-1:0] r_num,
    output logic [W-1:0]  r_data
);

    logic [W-1:0] mem [NREG];

    // Register writes; reset wins over a write on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: this storage is a handful of flops whose zero state is
            // architecturally visible, so it is cleared here; a RAM macro
            // could not be reset this way.
            for (int i = 0; i < NREG; i++) begin
                // NOTE: sequential state uses <= so every flop samples the
                // pre-edge values regardless of statement order.
                mem[i] <= '0;
            end
        end else if (w_en) begin
            mem[w_num] <= w_data;
        end
    end

    // Combinational read, no bypass: a same-edge write is seen next cycle.
    assign r_data = mem[r_num];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads two operands through a single register-file
// read port on consecutive cycles, shifts/selects them and presents
// Ain/Bin/ALUop to the ALU with a one-cycle valid strobe.
module operand_fetch
    import operand_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int NREG = NREG_DEF,
    parameter int RW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [RW-1:0] rn,
    input  logic [RW-1:0] rm,
    input  logic [1:0]    shift,
    input  logic [W-1:0]  sximm5,
    input  logic          asel,
    input  logic          bsel,
    input  logic [1:0]    op_in,
    input  logic          w_en,
    input  logic [RW-1:0] w_num,
    input  logic [W-1:0]  w_data,
    output logic [W-1:0]  Ain,
    output logic [W-1:0]  Bin,
    output logic [1:0]    ALUop,
    output logic          valid,
    output logic          busy
);

    state_e        state;
    state_e        state_nxt;

    // Fields captured at start so a fetch in progress ignores input changes.
    logic [RW-1:0] rn_q;
    logic [RW-1:0] rm_q;
    shift_e        shift_q;
    logic [W-1:0]  sximm5_q;
    logic          asel_q;
    logic          bsel_q;
    alu_op_e       op_q;

    // Operand holding registers.
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;

    logic [RW-1:0] r_num;
    logic [W-1:0]  r_data;
    logic [W-1:0]  b_shifted;

    logic          capture;
    assign capture = (state == IDLE) && start;

    operand_fetch_regfile #(
        .W    (W),
        .NREG (NREG),
        .RW   (RW)
    ) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .w_en   (w_en),
        .w_num  (w_num),
        .w_data (w_data),
        .r_num  (r_num),
        .r_data (r_data)
    );

    // State register; reset aborts any fetch in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state sequencing and read-port address selection.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_nxt = state;
        r_num     = rn_q;
        case (state)
            IDLE: if (start) state_nxt = RD_A;
            RD_A: state_nxt = RD_B;
            RD_B: begin
                r_num     = rm_q;
                state_nxt = OUT;
            end
            OUT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the instruction fields when a fetch is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            rn_q     <= '0;
            rm_q     <= '0;
            shift_q  <= SH_NONE;
            sximm5_q <= '0;
            asel_q   <= 1'b0;
            bsel_q   <= 1'b0;
            op_q     <= ADD;
        end else if (capture) begin
            rn_q     <= rn;
            rm_q     <= rm;
            shift_q  <= shift_e'(shift);
            sximm5_q <= sximm5;
            asel_q   <= asel;
            bsel_q   <= bsel;
            op_q     <= alu_op_e'(op_in);
        end
    end

    // Load A on the RD_A edge and B on the RD_B edge from the shared port.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (state == RD_A) a_q <= r_data;
            if (state == RD_B) b_q <= r_data;
        end
    end

    // Inline shifter on the held B operand.
    always_comb begin
        b_shifted = b_q;
        case (shift_q)
            SH_NONE: b_shifted = b_q;
            SH_LSL:  b_shifted = {b_q[W-2:0], 1'b0};
            SH_LSR:  b_shifted = {1'b0, b_q[W-1:1]};
            SH_ASR:  b_shifted = {b_q[W-1], b_q[W-1:1]};
            default: b_shifted = b_q;
        endcase
    end

    assign Ain   = asel_q ? '0 : a_q;
    assign Bin   = bsel_q ? sximm5_q : b_shifted;
    assign ALUop = op_q;
    assign valid = (state == OUT);
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed table, hand-written
// hazard/reset sequences and a randomized run against a register-array model.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  rn, rm, w_num;
    logic [1:0]  shift, op_in;
    logic [15:0] sximm5, w_data;
    logic        asel, bsel, w_en;
    logic [15:0] Ain, Bin;
    logic [1:0]  ALUop;
    logic        valid, busy;

    int errors = 0;
    int checks = 0;

    // Reference register contents, updated at each clock edge.
    logic [15:0] mdl [0:7];

    operand_fetch dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .rn     (rn),
        .rm     (rm),
        .shift  (shift),
        .sximm5 (sximm5),
        .asel   (asel),
        .bsel   (bsel),
        .op_in  (op_in),
        .w_en   (w_en),
        .w_num  (w_num),
        .w_data (w_data),
        .Ain    (Ain),
        .Bin    (Bin),
        .ALUop  (ALUop),
        .valid  (valid),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  rn;
        logic [2:0]  rm;
        logic [1:0]  sh;
        logic [15:0] imm;
        logic        asel;
        logic        bsel;
        logic [1:0]  op;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge; the model applies reset/write exactly as the edge does.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
        end else if (w_en) begin
            mdl[w_num] = w_data;
        end
        #1;
    endtask

    function automatic logic [15:0] shift_ref(input logic [15:0] b, input logic [1:0] sh);
        int v;
        v = int'(b);
        case (sh)
            2'd1:    return 16'((v * 2) % 65536);
            2'd2:    return 16'(v / 2);
            2'd3:    return 16'(v / 2 + ((v >= 32768) ? 32768 : 0));
            default: return b;
        endcase
    endfunction

    task automatic rand_write(input bit en);
        if (en) begin
            w_en   = 1'($urandom_range(0, 1));
            w_num  = 3'($urandom);
            w_data = 16'($urandom);
        end else begin
            w_en = 1'b0;
        end
    endtask

    task automatic scramble_fields();
        rn     = 3'($urandom);
        rm     = 3'($urandom);
        shift  = 2'($urandom);
        sximm5 = 16'($urandom);
        asel   = 1'($urandom);
        bsel   = 1'($urandom);
        op_in  = 2'($urandom);
        start  = 1'($urandom);
    endtask

    task automatic write_reg(input logic [2:0] n, input logic [15:0] d);
        w_en = 1'b1; w_num = n; w_data = d;
        tick();
        w_en = 1'b0;
    endtask

    // Full fetch with latency/pulse-width checks; returns DUT outputs seen
    // while valid and the model's expected operands.
    task automatic run_fetch(input logic [2:0] f_rn, input logic [2:0] f_rm,
                             input logic [1:0] f_sh, input logic [15:0] f_imm,
                             input logic f_asel, input logic f_bsel,
                             input logic [1:0] f_op, input bit rnd_wr,
                             output logic [15:0] got_a, output logic [15:0] got_b,
                             output logic [1:0] got_op,
                             output logic [15:0] mdl_a, output logic [15:0] mdl_b);
        logic [15:0] a_val, b_val;
        check("idle_before_start", busy, 1'b0);
        rn = f_rn; rm = f_rm; shift = f_sh; sximm5 = f_imm;
        asel = f_asel; bsel = f_bsel; op_in = f_op; start = 1'b1;
        rand_write(rnd_wr);
        tick();
        check("busy_after_start", busy, 1'b1);
        check("valid_low_1", valid, 1'b0);
        scramble_fields();
        rand_write(rnd_wr);
        a_val = mdl[f_rn];
        tick();
        check("valid_low_2", valid, 1'b0);
        scramble_fields();
        rand_write(rnd_wr);
        b_val = mdl[f_rm];
        tick();
        check("valid_high_3", valid, 1'b1);
        check("busy_in_out", busy, 1'b1);
        got_a  = Ain;
        got_b  = Bin;
        got_op = ALUop;
        start = 1'b0;
        rand_write(rnd_wr);
        tick();
        check("valid_one_cycle", valid, 1'b0);
        check("idle_after_out", busy, 1'b0);
        w_en  = 1'b0;
        mdl_a = f_asel ? 16'h0000 : a_val;
        mdl_b = f_bsel ? f_imm : shift_ref(b_val, f_sh);
    endtask

    initial begin
        logic [15:0] ga, gb, ma, mb;
        logic [1:0]  gop;
        logic [2:0]  r_rn, r_rm;
        logic [1:0]  r_sh, r_op;
        logic [15:0] r_imm;
        logic        r_as, r_bs;

        tbl[0] = '{3'd1, 3'd2, 2'b00, 16'h0000, 1'b0, 1'b0, 2'b00, 16'h0007, 16'h0003};
        tbl[1] = '{3'd1, 3'd3, 2'b01, 16'h0000, 1'b0, 1'b0, 2'b01, 16'h0007, 16'h0002};
        tbl[2] = '{3'd2, 3'd3, 2'b10, 16'h0000, 1'b0, 1'b0, 2'b10, 16'h0003, 16'h4000};
        tbl[3] = '{3'd0, 3'd3, 2'b11, 16'h0000, 1'b0, 1'b0, 2'b11, 16'h0000, 16'hC000};
        tbl[4] = '{3'd1, 3'd2, 2'b00, 16'hFFF0, 1'b1, 1'b1, 2'b01, 16'h0000, 16'hFFF0};
        tbl[5] = '{3'd3, 3'd1, 2'b00, 16'h0000, 1'b0, 1'b0, 2'b10, 16'h8001, 16'h0007};
        tbl[6] = '{3'd3, 3'd3, 2'b11, 16'h1234, 1'b0, 1'b1, 2'b00, 16'h8001, 16'h1234};

        reset = 1'b1; start = 1'b0; rn = '0; rm = '0; shift = '0; sximm5 = '0;
        asel = 1'b0; bsel = 1'b0; op_in = '0; w_en = 1'b0; w_num = '0; w_data = '0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_ain", Ain, 16'h0000);
        check("rst_bin", Bin, 16'h0000);
        check("rst_aluop", ALUop, 2'b00);
        check("rst_valid", valid, 1'b0);
        check("rst_busy", busy, 1'b0);

        write_reg(3'd1, 16'h0007);
        write_reg(3'd2, 16'h0003);
        write_reg(3'd3, 16'h8001);

        // Directed vectors against fixed expected values.
        for (int i = 0; i < 7; i++) begin
            run_fetch(tbl[i].rn, tbl[i].rm, tbl[i].sh, tbl[i].imm, tbl[i].asel,
                      tbl[i].bsel, tbl[i].op, 1'b0, ga, gb, gop, ma, mb);
            check($sformatf("tbl%0d_ain", i), ga, tbl[i].exp_a);
            check($sformatf("tbl%0d_bin", i), gb, tbl[i].exp_b);
            check($sformatf("tbl%0d_aluop", i), gop, tbl[i].op);
        end

        // Same-edge write of R4 during RD_A: A sees the old value, B (read
        // one edge later) sees the new one.
        rn = 3'd4; rm = 3'd4; shift = 2'b00; asel = 1'b0; bsel = 1'b0; op_in = 2'b00;
        start = 1'b1;
        tick();
        start = 1'b0;
        w_en = 1'b1; w_num = 3'd4; w_data = 16'h1234;
        tick();
        w_en = 1'b0;
        tick();
        check("hazard_valid", valid, 1'b1);
        check("hazard_ain_old", Ain, 16'h0000);
        check("hazard_bin_new", Bin, 16'h1234);
        tick();
        run_fetch(3'd4, 3'd0, 2'b00, 16'h0000, 1'b0, 1'b0, 2'b00, 1'b0, ga, gb, gop, ma, mb);
        check("hazard_followup_ain", ga, 16'h1234);

        // start held high from OUT is taken on the next IDLE cycle.
        rn = 3'd2; rm = 3'd1; shift = 2'b00; sximm5 = '0; asel = 1'b0; bsel = 1'b0;
        op_in = 2'b11; start = 1'b1;
        tick();
        tick();
        tick();
        check("held_out_valid", valid, 1'b1);
        tick();
        check("held_idle_valid", valid, 1'b0);
        check("held_idle_busy", busy, 1'b0);
        tick();
        check("held_retaken_busy", busy, 1'b1);
        start = 1'b0;
        tick();
        tick();
        check("held_second_valid", valid, 1'b1);
        check("held_second_ain", Ain, 16'h0003);
        check("held_second_aluop", ALUop, 2'b11);
        tick();

        // Reset during RD_B aborts the fetch and discards a same-edge write.
        rn = 3'd1; rm = 3'd6; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("abort_busy_rd_b", busy, 1'b1);
        reset = 1'b1; w_en = 1'b1; w_num = 3'd6; w_data = 16'hABCD;
        tick();
        reset = 1'b0; w_en = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_valid", valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_pulse", valid, 1'b0);
        end
        run_fetch(3'd1, 3'd6, 2'b00, 16'h0000, 1'b0, 1'b0, 2'b00, 1'b0, ga, gb, gop, ma, mb);
        check("abort_r1_cleared", ga, 16'h0000);
        check("abort_write_dropped", gb, 16'h0000);

        // Randomized fetches with concurrent writes against the model.
        for (int i = 0; i < 8; i++) write_reg(3'(i), 16'($urandom));
        for (int t = 0; t < 60; t++) begin
            r_rn = 3'($urandom); r_rm = 3'($urandom); r_sh = 2'($urandom);
            r_imm = 16'($urandom); r_as = 1'($urandom_range(0, 3) == 0);
            r_bs = 1'($urandom_range(0, 3) == 0); r_op = 2'($urandom);
            run_fetch(r_rn, r_rm, r_sh, r_imm, r_as, r_bs, r_op, 1'b1, ga, gb, gop, ma, mb);
            check($sformatf("rnd%0d_ain", t), ga, ma);
            check($sformatf("rnd%0d_bin", t), gb, mb);
            check($sformatf("rnd%0d_aluop", t), gop, r_op);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
